lsu_mem: RTL



---
 rtl/lsu_mem.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lsu_mem.sv
// Load/store unit with a private word-organised data SRAM, one access in flight.
// Byte/half/word loads and stores with RV32I extension; LAT models SRAM wait states.
module lsu_mem #(
  parameter logic [31:0] BASE  = 32'h1001_0000,
  parameter int          DEPTH = 1024,
  parameter int          LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  LAT_LAST = 4'(LAT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;

  logic        l_we, l_uns;
  logic [1:0]  l_width;
  logic [31:0] l_addr, l_wdata;

  logic        accept, op_fire;
  logic        op_we, op_uns;
  logic [1:0]  op_width;
  logic [31:0] op_addr, op_wdata;

  logic [31:0] off;
  logic        misalign, fault;
  logic [AW-1:0] idx;
  logic [31:0] word, ld_val, st_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [3:0]  be;

  logic [31:0] mem [DEPTH];

  assign ready   = (state == IDLE);
  assign valid   = (state == RESP);
  assign accept  = req && ready;
  assign op_fire = (accept && (LAT == 0)) || ((state == WAIT) && (cnt == LAT_LAST));

  // With LAT=0 the access happens on the acceptance edge, so it must see the live inputs.
  always_comb begin
    op_we    = l_we;
    op_uns   = l_uns;
    op_width = l_width;
    op_addr  = l_addr;
    op_wdata = l_wdata;
    if (state == IDLE) begin
      op_we    = we;
      op_uns   = unsigned_ld;
      op_width = width;
      op_addr  = addr;
      op_wdata = wdata;
    end
  end

  // Unsigned offset: addresses below BASE wrap high and land outside SPAN.
  assign off = op_addr - BASE;
  assign idx = off[AW+1:2];

  always_comb begin
    misalign = 1'b0;
    case (op_width)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = op_addr[0];
      2'b10:   misalign = |op_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  assign fault = misalign || ({1'b0, off} >= SPAN);

  assign word     = mem[idx];
  assign byte_sel = word[{op_addr[1:0], 3'b000} +: 8];
  assign half_sel = op_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_val  = word;
    be      = 4'hF;
    st_data = op_wdata;
    case (op_width)
      2'b00: begin
        ld_val  = {{24{~op_uns & byte_sel[7]}}, byte_sel};
        be      = 4'b0001 << op_addr[1:0];
        st_data = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        ld_val  = {{16{~op_uns & half_sel[15]}}, half_sel};
        be      = op_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{op_wdata[15:0]}};
      end
      default: begin
        ld_val  = word;
        be      = 4'hF;
        st_data = op_wdata;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt   <= 4'd0;
          state <= (LAT > 0) ? WAIT : RESP;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAT_LAST) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (op_fire) begin
        err   <= fault;
        rdata <= (fault || op_we) ? 32'd0 : ld_val;
      end
    end
  end

  // Request capture is a pure data register; its contents matter only after an acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      l_we    <= we;
      l_uns   <= unsigned_ld;
      l_width <= width;
      l_addr  <= addr;
      l_wdata <= wdata;
    end
  end

  // NOTE: the SRAM array has no reset; a reset edge only suppresses a pending write.
  always_ff @(posedge clk) begin
    if (rst && op_fire && op_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule
